// File: rtl/jtframe_ddr_pkg.sv
// Shared DDRAM line-fetch definitions: bus widths and fetch FSM states.
package jtframe_ddr_pkg;

  localparam int unsigned AW  = 29;  // DDRAM word address width (64-bit words)
  localparam int unsigned DW  = 64;  // DDRAM data width
  localparam int unsigned BEW = 8;   // DDRAM byte-enable width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA
  } state_e;

endpackage

// File: rtl/jtframe_ddr_linefetch_if.sv
// MiSTer DDRAM port as seen by a read-only client.
interface jtframe_ddr_linefetch_if;
  import jtframe_ddr_pkg::*;

  logic           ddram_clk;
  logic           ddram_busy;
  logic [7:0]     ddram_burstcnt;
  logic [AW-1:0]  ddram_addr;
  logic [DW-1:0]  ddram_dout;
  logic           ddram_dout_ready;
  logic           ddram_rd;
  logic [DW-1:0]  ddram_din;
  logic [BEW-1:0] ddram_be;
  logic           ddram_we;

  // Client side: issues requests, receives read data
  modport master (
    output ddram_clk, ddram_burstcnt, ddram_addr, ddram_rd,
           ddram_din, ddram_be, ddram_we,
    input  ddram_busy, ddram_dout, ddram_dout_ready
  );

  // Memory side: accepts requests, returns read data
  modport slave (
    input  ddram_clk, ddram_burstcnt, ddram_addr, ddram_rd,
           ddram_din, ddram_be, ddram_we,
    output ddram_busy, ddram_dout, ddram_dout_ready
  );

endinterface

// File: rtl/jtframe_ddr_lbuf.sv
// Ping-pong line buffer: simple dual-port RAM, one write port, one registered read port.
module jtframe_ddr_lbuf #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Write incoming beats; read with one cycle of latency
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/jtframe_ddr_linefetch.sv
// Video-side DDRAM reader: fetches one line per HS into a ping-pong buffer.
module jtframe_ddr_linefetch
  import jtframe_ddr_pkg::*;
#(
  parameter int unsigned LW = 6,
  parameter int unsigned BW = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hs,
  input  logic                      vs,
  input  logic [AW-1:0]             base_addr,
  jtframe_ddr_linefetch_if.master   ddr,
  input  logic [LW-1:0]             rd_addr,
  output logic [DW-1:0]             rd_data,
  output logic                      fetching,
  output logic                      overrun
);

  localparam int unsigned LINE_WORDS = 2**LW;
  localparam int unsigned BURST      = 2**BW;

  state_e        state_q, state_d;
  logic          hsl_q, vsl_q;
  logic          wr_bank_q, wr_bank_d;
  logic [LW-1:0] word_cnt_q, word_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [AW-1:0] line_addr_q, line_addr_d;
  logic [AW-1:0] ddr_addr_q, ddr_addr_d;
  logic          rd_q, rd_d;
  logic          fetching_q, fetching_d;
  logic          overrun_q, overrun_d;
  logic          buf_we;
  logic          hs_edge, vs_edge;

  assign hs_edge = hs && !hsl_q;
  assign vs_edge = vs && !vsl_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hsl_q       <= 1'b0;
      vsl_q       <= 1'b0;
      wr_bank_q   <= 1'b0;
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      line_addr_q <= '0;
      ddr_addr_q  <= '0;
      rd_q        <= 1'b0;
      fetching_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hsl_q       <= hs;
      vsl_q       <= vs;
      wr_bank_q   <= wr_bank_d;
      word_cnt_q  <= word_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      line_addr_q <= line_addr_d;
      ddr_addr_q  <= ddr_addr_d;
      rd_q        <= rd_d;
      fetching_q  <= fetching_d;
      overrun_q   <= overrun_d;
    end
  end

  // Fetch sequencing: one burst outstanding at a time, line done after LINE_WORDS beats
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    word_cnt_d  = word_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    line_addr_d = line_addr_q;
    ddr_addr_d  = ddr_addr_q;
    rd_d        = rd_q;
    fetching_d  = fetching_q;
    overrun_d   = overrun_q;
    buf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hs_edge) begin
          wr_bank_d  = ~wr_bank_q;
          word_cnt_d = '0;
          fetching_d = 1'b1;
          ddr_addr_d = vs_edge ? base_addr : line_addr_q;
          rd_d       = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!ddr.ddram_busy) begin
          rd_d       = 1'b0;
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ddr.ddram_dout_ready) begin
          buf_we     = 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (&beat_cnt_q) begin
            if (&word_cnt_q) begin
              line_addr_d = line_addr_q + AW'(LINE_WORDS);
              fetching_d  = 1'b0;
              state_d     = ST_IDLE;
            end else begin
              ddr_addr_d = ddr_addr_q + AW'(BURST);
              rd_d       = 1'b1;
              state_d    = ST_REQ;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // vs rewinds after any end-of-line advance; an hs during a fetch then re-flags overrun
    if (vs_edge) begin
      line_addr_d = base_addr;
      overrun_d   = 1'b0;
    end
    if (hs_edge && state_q != ST_IDLE) overrun_d = 1'b1;
  end

  assign ddr.ddram_clk      = clk;
  assign ddr.ddram_burstcnt = 8'(BURST);
  assign ddr.ddram_addr     = ddr_addr_q;
  assign ddr.ddram_rd       = rd_q;
  assign ddr.ddram_din      = '0;
  assign ddr.ddram_be       = '1;
  assign ddr.ddram_we       = 1'b0;
  assign fetching           = fetching_q;
  assign overrun            = overrun_q;

  jtframe_ddr_lbuf #(
    .AW (LW + 1),
    .DW (DW)
  ) u_lbuf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i ({wr_bank_q, word_cnt_q}),
    .wdata_i (ddr.ddram_dout),
    .raddr_i ({~wr_bank_q, rd_addr}),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_jtframe_ddr_linefetch.sv
// Self-checking bench for jtframe_ddr_linefetch with a transaction-level DDRAM and line model.
module tb_jtframe_ddr_linefetch;
  import jtframe_ddr_pkg::*;

  localparam int unsigned LW = 6;
  localparam int unsigned BW = 3;
  localparam int unsigned LINE_WORDS = 64;
  localparam int unsigned BURST = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hs = 1'b0;
  logic          vs = 1'b0;
  logic [28:0]   base_addr = '0;
  logic [LW-1:0] rd_addr = '0;
  logic [63:0]   rd_data;
  logic          fetching, overrun;

  jtframe_ddr_linefetch_if ddr();

  jtframe_ddr_linefetch #(.LW(LW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .base_addr(base_addr), .ddr(ddr),
    .rd_addr(rd_addr), .rd_data(rd_data), .fetching(fetching), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the line buffer must hold and which requests must appear
  typedef struct { logic [63:0] data; int unsigned ep; } beat_t;
  logic [63:0]  exp_mem [2][LINE_WORDS];
  bit           exp_vld [2][LINE_WORDS];
  bit           m_fetch, m_bank, m_over, ph, pv;
  logic [28:0]  m_line;
  int unsigned  m_words;
  logic [28:0]  exp_req[$];
  logic [28:0]  acc_log[$];
  beat_t        beat_q[$];
  int unsigned  epoch = 0;
  int unsigned  cur_ep;
  bit           prev_hold;
  logic [28:0]  prev_addr;

  // DDRAM data return: queued beats, one every cycle except every 4th
  initial begin : mem_drv
    beat_t b;
    int unsigned gap;
    gap = 0;
    cur_ep = 0;
    ddr.ddram_dout_ready = 1'b0;
    ddr.ddram_dout = '0;
    forever begin
      @(posedge clk); #1;
      gap++;
      if (beat_q.size() > 0 && (gap % 4) != 3) begin
        b = beat_q.pop_front();
        ddr.ddram_dout = b.data;
        ddr.ddram_dout_ready = 1'b1;
        cur_ep = b.ep;
      end else begin
        ddr.ddram_dout_ready = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, then advance the model for the next edge
  always @(negedge clk) begin : model
    bit was_fetch, hs_e, vs_e;
    if (rst) begin
      m_fetch = 0; m_bank = 0; m_over = 0; m_line = '0; m_words = 0;
      ph = 0; pv = 0; prev_hold = 0;
      exp_req.delete();
      chk("rst_rd", ddr.ddram_rd, 0);
      chk("rst_fetching", fetching, 0);
      chk("rst_overrun", overrun, 0);
    end else begin
      chk("fetching", fetching, m_fetch);
      chk("overrun", overrun, m_over);
      chk("burstcnt", ddr.ddram_burstcnt, 64'd8);
      chk("be", ddr.ddram_be, 64'hFF);
      chk("we", ddr.ddram_we, 0);
      chk("din", ddr.ddram_din, 0);
      chk("ddram_clk", ddr.ddram_clk, clk);
      if (prev_hold) begin
        chk("hold_rd", ddr.ddram_rd, 1);
        chk("hold_addr", ddr.ddram_addr, prev_addr);
      end
      prev_hold = ddr.ddram_rd && ddr.ddram_busy;
      prev_addr = ddr.ddram_addr;

      if (ddr.ddram_rd && !ddr.ddram_busy) begin
        acc_log.push_back(ddr.ddram_addr);
        if (exp_req.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL spurious_req: addr 0x%0h requested, none expected at %0t",
                   ddr.ddram_addr, $time);
        end else begin
          chk("req_addr", ddr.ddram_addr, exp_req.pop_front());
        end
        for (int i = 0; i < BURST; i++)
          beat_q.push_back('{data: 64'(ddr.ddram_addr + 29'(i)), ep: epoch});
      end

      was_fetch = m_fetch;
      if (ddr.ddram_dout_ready && cur_ep == epoch && m_fetch) begin
        exp_mem[m_bank][m_words] = ddr.ddram_dout;
        exp_vld[m_bank][m_words] = 1;
        m_words++;
        if (m_words == LINE_WORDS) begin
          m_fetch = 0;
          m_line = m_line + 29'(LINE_WORDS);
        end
      end

      hs_e = hs && !ph;
      vs_e = vs && !pv;
      ph = hs;
      pv = vs;
      if (vs_e) begin
        m_line = base_addr;
        m_over = 0;
      end
      if (hs_e) begin
        if (was_fetch) m_over = 1;
        else begin
          m_bank = ~m_bank;
          m_fetch = 1;
          m_words = 0;
          for (int j = 0; j < LINE_WORDS / BURST; j++)
            exp_req.push_back(m_line + 29'(j * BURST));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_hs();
    hs = 1; tick(1); hs = 0;
  endtask

  task automatic pulse_vs();
    vs = 1; tick(1); vs = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (fetching && n < 600) begin tick(1); n++; end
    if (fetching) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: fetching still 1 after %0d cycles, expected 0", name, n);
    end
    tick(2);
  endtask

  task automatic wait_words(input int unsigned w);
    int n;
    n = 0;
    while (m_words < w && n < 600) begin tick(1); n++; end
    if (m_words < w) begin
      n_chk++; n_err++;
      $display("FAIL words_timeout: got %0d words, expected %0d", m_words, w);
    end
  endtask

  task automatic check_rd(input string name, input int unsigned k, input logic [63:0] lit);
    rd_addr = LW'(k);
    @(posedge clk);
    @(negedge clk);
    if (exp_vld[int'(!m_bank)][k]) chk({name, "_model"}, rd_data, exp_mem[int'(!m_bank)][k]);
    chk(name, rd_data, lit);
    tick(1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin : stim
    int base, n;
    ddr.ddram_busy = 1'b0;
    tick(3);
    rst = 0;
    tick(3);

    // Idle after reset
    chk("t1_rd", ddr.ddram_rd, 0);
    chk("t1_we", ddr.ddram_we, 0);
    chk("t1_be", ddr.ddram_be, 64'hFF);
    chk("t1_burstcnt", ddr.ddram_burstcnt, 64'd8);
    chk("t1_fetching", fetching, 0);

    // First line from 0x100, second request stalled for 10 cycles
    base_addr = 29'h100;
    base = acc_log.size();
    pulse_vs();
    pulse_hs();
    n = 0;
    while (acc_log.size() < base + 1 && n < 100) begin tick(1); n++; end
    chk("t2_first_accept", acc_log.size(), base + 1);
    ddr.ddram_busy = 1'b1;
    n = 0;
    while (!ddr.ddram_rd && n < 200) begin tick(1); n++; end
    chk("t3_rd_raised", ddr.ddram_rd, 1);
    chk("t3_addr", ddr.ddram_addr, 29'h108);
    tick(10);
    chk("t3_single_accept", acc_log.size(), base + 1);
    chk("t3_addr_held", ddr.ddram_addr, 29'h108);
    ddr.ddram_busy = 1'b0;
    wait_done("t2");
    chk("t2_nbursts", acc_log.size(), base + 8);
    chk("t2_addr0", acc_log[base], 29'h100);
    chk("t2_addr1", acc_log[base + 1], 29'h108);
    chk("t2_addr7", acc_log[base + 7], 29'h138);

    // Next line continues at 0x140; the completed line becomes visible
    base = acc_log.size();
    pulse_hs();
    check_rd("t2_rd5", 5, 64'h105);
    check_rd("t2_rd0", 0, 64'h100);
    check_rd("t2_rd63", 63, 64'h13F);
    wait_done("t4a");
    chk("t4_next_line", acc_log[base], 29'h140);

    // vs rewinds to the frame base
    base = acc_log.size();
    pulse_vs();
    pulse_hs();
    check_rd("t4_rd5", 5, 64'h145);
    wait_done("t4b");
    chk("t4_rewind", acc_log[base], 29'h100);

    // Overrun: hs during a fetch is flagged and otherwise ignored
    base = acc_log.size();
    pulse_hs();
    wait_words(20);
    pulse_hs();
    tick(1);
    chk("t5_overrun_set", overrun, 1);
    check_rd("t5_no_toggle", 7, 64'h107);
    wait_done("t5");
    chk("t5_nbursts", acc_log.size(), base + 8);
    chk("t5_last_burst", acc_log[base + 7], 29'h178);
    check_rd("t5_still_old", 7, 64'h107);
    chk("t5_overrun_sticky", overrun, 1);
    pulse_vs();
    tick(1);
    chk("t5_overrun_clr", overrun, 0);

    // Async reset mid-burst; trailing beats must not touch the buffer
    pulse_hs();
    wait_words(5);
    #2;
    rst = 1;
    epoch++;
    #1;
    chk("t6_rd_drop", ddr.ddram_rd, 0);
    chk("t6_fetching_drop", fetching, 0);
    @(posedge clk);
    #2;
    rst = 0;
    tick(1);
    n = 0;
    while (beat_q.size() > 0 && n < 50) begin tick(1); n++; end
    tick(3);
    base = acc_log.size();
    pulse_hs();
    check_rd("t6_keep0", 0, 64'h140);
    check_rd("t6_keep1", 1, 64'h141);
    check_rd("t6_keep2", 2, 64'h142);
    wait_done("t6a");
    chk("t6_restart_addr", acc_log[base], 29'h000);
    pulse_hs();
    check_rd("t6_new_line", 5, 64'h5);
    wait_done("t6b");

    chk("req_queue_empty", exp_req.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
